// File: rtl/cpm_seq_ctrl_if.sv
// Monitor-bus side of the CPM sequencer: run request/config in, pin drives and run result out.
interface cpm_seq_ctrl_if;
  logic        start;
  logic [3:0]  cfg_sel;
  logic [4:0]  thresh;
  logic [15:0] cpm_out;
  logic        sc_din;
  logic        sc_clk;
  logic        sc_len;
  logic        cpl_clk;
  logic        tdc_clk;
  logic        busy;
  logic        done;
  logic [4:0]  result;
  logic        alarm;
  logic        err;

  modport master (
    output start, cfg_sel, thresh, cpm_out,
    input  sc_din, sc_clk, sc_len, cpl_clk, tdc_clk, busy, done, result, alarm, err
  );

  modport slave (
    input  start, cfg_sel, thresh, cpm_out,
    output sc_din, sc_clk, sc_len, cpl_clk, tdc_clk, busy, done, result, alarm, err
  );
endinterface

// File: rtl/cpm_seq_ctrl.sv
// CPM sequencer: optional 4-bit scan reload, SAMPLES launch/capture windows, min-edge result.
// DONE at cycle 1+L+SAMPLES*P after START; START is ignored (not queued) while busy.
module cpm_seq_ctrl #(
  parameter int SC_HALF = 2,
  parameter int CAP_DLY = 3,
  parameter int RELAX   = 4,
  parameter int SAMPLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  cpm_seq_ctrl_if.slave bus
);
  localparam int P    = CAP_DLY + 3 + RELAX;
  localparam int BITP = 2 * SC_HALF;
  localparam int CMAX = (BITP > P) ? BITP : P;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, LATCH, MEAS, EVAL} state_t;

  state_t        state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [3:0]    idx, nxt_idx;
  logic [3:0]    cfg_q, nxt_cfg, loaded, nxt_loaded;
  logic          cfg_valid, nxt_valid;
  logic [4:0]    thr_q, nxt_thr;
  logic [4:0]    run_min, nxt_min;
  logic          run_err, nxt_err;
  logic [4:0]    smp_cnt;
  logic          smp_bub;
  logic          sc_din_d, sc_clk_d, sc_len_d, cpl_d, tdc_d, busy_d, done_d;

  // {bubble, leading-ones count}, bit 15 is the first delay cell
  function automatic logic [5:0] decode(input logic [15:0] w);
    logic [4:0] c;
    logic       z;
    logic       b;
    c = '0;
    z = 1'b0;
    b = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (!w[i])  z = 1'b1;
      else if (z) b = 1'b1;
      else        c = c + 5'd1;
    end
    return {b, c};
  endfunction

  always_comb {smp_bub, smp_cnt} = decode(bus.cpm_out);

  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_idx    = idx;
    nxt_cfg    = cfg_q;
    nxt_thr    = thr_q;
    nxt_loaded = loaded;
    nxt_valid  = cfg_valid;
    nxt_min    = run_min;
    nxt_err    = run_err;
    case (state)
      IDLE: if (bus.start) begin
        nxt_cfg   = bus.cfg_sel;
        nxt_thr   = bus.thresh;
        nxt_min   = 5'd16;
        nxt_err   = 1'b0;
        nxt_cnt   = '0;
        nxt_idx   = '0;
        nxt_state = (!cfg_valid || bus.cfg_sel != loaded) ? SHIFT : MEAS;
      end
      SHIFT: if (cnt == CW'(BITP - 1)) begin
        nxt_cnt = '0;
        if (idx == 4'd3) begin
          nxt_state = LATCH;
          nxt_idx   = '0;
        end else begin
          nxt_idx = idx + 4'd1;
        end
      end else begin
        nxt_cnt = cnt + 1'b1;
      end
      LATCH: if (cnt == CW'(BITP - 1)) begin
        nxt_state  = MEAS;
        nxt_cnt    = '0;
        nxt_valid  = 1'b1;
        nxt_loaded = cfg_q;
      end else begin
        nxt_cnt = cnt + 1'b1;
      end
      MEAS: begin
        // capture word is the one present the cycle after the capture edge falls
        if (cnt == CW'(CAP_DLY + 1)) begin
          if (smp_cnt < run_min) nxt_min = smp_cnt;
          if (smp_bub)           nxt_err = 1'b1;
        end
        if (cnt == CW'(P - 1)) begin
          nxt_cnt = '0;
          if (idx == 4'(SAMPLES - 1)) nxt_state = EVAL;
          else                        nxt_idx   = idx + 4'd1;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      EVAL:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase

    // pin values are decoded from the next state so every output is a flop
    sc_din_d = (nxt_state == SHIFT) ? nxt_cfg[nxt_idx[1:0]] : 1'b0;
    sc_clk_d = (nxt_state == SHIFT) && (nxt_cnt >= CW'(SC_HALF));
    sc_len_d = (nxt_state == LATCH) && (nxt_cnt < CW'(SC_HALF));
    cpl_d    = (nxt_state == MEAS)  && (nxt_cnt <= CW'(CAP_DLY));
    tdc_d    = (nxt_state == MEAS)  && (nxt_cnt == CW'(CAP_DLY));
    busy_d   = (nxt_state != IDLE);
    done_d   = (nxt_state == EVAL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      cfg_q       <= '0;
      thr_q       <= '0;
      loaded      <= '0;
      cfg_valid   <= 1'b0;
      run_min     <= '0;
      run_err     <= 1'b0;
      bus.sc_din  <= 1'b0;
      bus.sc_clk  <= 1'b0;
      bus.sc_len  <= 1'b0;
      bus.cpl_clk <= 1'b0;
      bus.tdc_clk <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.result  <= '0;
      bus.alarm   <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      idx         <= nxt_idx;
      cfg_q       <= nxt_cfg;
      thr_q       <= nxt_thr;
      loaded      <= nxt_loaded;
      cfg_valid   <= nxt_valid;
      run_min     <= nxt_min;
      run_err     <= nxt_err;
      bus.sc_din  <= sc_din_d;
      bus.sc_clk  <= sc_clk_d;
      bus.sc_len  <= sc_len_d;
      bus.cpl_clk <= cpl_d;
      bus.tdc_clk <= tdc_d;
      bus.busy    <= busy_d;
      bus.done    <= done_d;
      if (done_d) begin
        bus.result <= nxt_min;
        bus.alarm  <= (nxt_min < thr_q);
        bus.err    <= nxt_err;
      end
    end
  end
endmodule

// File: tb/tb_cpm_seq_ctrl.sv
// Directed bench for cpm_seq_ctrl: timeline model checked every cycle plus literal pins.
module tb_cpm_seq_ctrl;
  localparam int H  = 2;
  localparam int CD = 3;
  localparam int RX = 4;
  localparam int S  = 4;
  localparam int P  = CD + 3 + RX;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  cpm_seq_ctrl_if bus();

  cpm_seq_ctrl #(.SC_HALF(H), .CAP_DLY(CD), .RELAX(RX), .SAMPLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [15:0] words   [S];
  logic [15:0] m_words [S];
  logic        m_active = 1'b0, m_finished = 1'b0, m_valid = 1'b0, m_reload = 1'b0;
  logic [3:0]  m_loaded = '0, m_cfg = '0;
  logic [4:0]  m_thr = '0, m_min = '0, h_res = '0;
  logic        m_err = 1'b0, m_alarm = 1'b0, h_alarm = 1'b0, h_err = 1'b0;
  int          m_t0 = 0, m_total = 0, m_L = 0;

  int          first_cpl = -1, done_k = -1, rises = 0;
  logic [3:0]  rise_bits = '0, chain = '0, latched = '0;

  function automatic logic [13:0] act_vec();
    return {bus.sc_din, bus.sc_clk, bus.sc_len, bus.cpl_clk, bus.tdc_clk,
            bus.busy, bus.done, bus.result, bus.alarm, bus.err};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Run-level model: acceptance, reload decision and expected result per START
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_active = 1'b0;
      m_valid  = 1'b0;
      h_res    = '0;
      h_alarm  = 1'b0;
      h_err    = 1'b0;
    end else if (m_active) begin
      if (cyc - 1 == m_t0 + m_total) begin
        m_active   = 1'b0;
        m_finished = 1'b1;
        h_res      = m_min;
        h_alarm    = m_alarm;
        h_err      = m_err;
      end
    end else if (bus.start) begin
      int          c;
      logic [15:0] t;
      m_active = 1'b1;
      m_t0     = cyc - 1;
      m_cfg    = bus.cfg_sel;
      m_thr    = bus.thresh;
      m_reload = !m_valid || (bus.cfg_sel != m_loaded);
      m_valid  = 1'b1;
      m_loaded = bus.cfg_sel;
      m_L      = m_reload ? 10 * H : 0;
      m_total  = 1 + m_L + S * P;
      m_words  = words;
      m_min    = 5'd16;
      m_err    = 1'b0;
      for (int s = 0; s < S; s++) begin
        c = 0;
        while (c < 16 && m_words[s][15 - c]) c++;
        t = 16'hFFFF >> c;
        if (m_words[s] != ~t) m_err = 1'b1;
        if (c < int'(m_min)) m_min = 5'(c);
      end
      m_alarm = (m_min < m_thr);
    end
  end

  // Per-cycle expected pin timeline, derived from cycle offset within the run
  initial forever begin
    logic        e_din, e_clk, e_len, e_cpl, e_tdc, e_busy, e_done, e_alarm, e_err;
    logic [4:0]  e_res;
    logic [13:0] exp_v, act_v;
    int          k, j;
    @(negedge clk);
    {e_din, e_clk, e_len, e_cpl, e_tdc, e_busy, e_done, e_alarm, e_err} = '0;
    e_res = '0;
    if (!rst_n) begin
      bus.cpm_out = 16'($urandom);
    end else begin
      e_res   = h_res;
      e_alarm = h_alarm;
      e_err   = h_err;
      if (m_active) begin
        k      = cyc - m_t0;
        e_busy = (k >= 1 && k <= m_total);
        if (k >= 1 && k <= m_L) begin
          j = k - 1;
          if (k <= 8 * H) begin
            e_clk = ((j % (2 * H)) >= H);
            e_din = m_cfg[j / (2 * H)];
          end else begin
            e_len = ((j - 8 * H) < H);
          end
        end else if (k > m_L && k <= m_L + S * P) begin
          j           = (k - m_L - 1) % P;
          e_cpl       = (j <= CD);
          e_tdc       = (j == CD);
          bus.cpm_out = m_words[(k - m_L - 1) / P];
        end else if (k == m_total) begin
          e_done  = 1'b1;
          e_res   = m_min;
          e_alarm = m_alarm;
          e_err   = m_err;
        end
        if (bus.cpl_clk && first_cpl < 0) first_cpl = k;
        if (bus.done) done_k = k;
      end
    end
    exp_v = {e_din, e_clk, e_len, e_cpl, e_tdc, e_busy, e_done, e_res, e_alarm, e_err};
    act_v = act_vec();
    n_vec++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL cycle %0d pins{din,sck,len,cpl,tdc,busy,done,res,alarm,err}: got %b want %b",
               cyc, act_v, exp_v);
    end
  end

  // Behavioural 4-stage scan chain: first bit shifted ends up in S[4]
  initial forever begin
    @(posedge bus.sc_clk);
    rises++;
    rise_bits = {rise_bits[2:0], bus.sc_din};
    chain     = {bus.sc_din, chain[3:1]};
  end

  initial forever begin
    @(posedge bus.sc_len);
    latched = chain;
  end

  task automatic do_start(input logic [3:0] cfg, input logic [4:0] thr,
                          input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2, input logic [15:0] w3);
    @(negedge clk);
    words[0]    = w0;
    words[1]    = w1;
    words[2]    = w2;
    words[3]    = w3;
    first_cpl   = -1;
    done_k      = -1;
    rises       = 0;
    m_finished  = 1'b0;
    bus.cfg_sel = cfg;
    bus.thresh  = thr;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!m_finished && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_finished"}, int'(m_finished), 1);
    @(negedge clk);
  endtask

  task automatic abort_after(input int n);
    repeat (n) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("abort_outputs_zero", int'(act_vec()), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_no_done", done_k, -1);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.cfg_sel = '0;
    bus.thresh  = '0;
    #1 rst_n = 1'b0;
    repeat (8) begin
      @(negedge clk);
      bus.start = 1'($urandom);
    end
    #1 check("reset_outputs", int'(act_vec()), 0);
    @(negedge clk);
    bus.start = 1'b0;
    rst_n     = 1'b1;

    // reload run, counts 9,7,8,10
    do_start(4'b1010, 5'd8, 16'hFF80, 16'hFE00, 16'hFF00, 16'hFFC0);
    wait_done("run_a");
    check("a_sc_rises", rises, 4);
    check("a_din_at_rises", int'(rise_bits), 4'b0101);
    check("a_chain_latched", int'(latched), 4'b1010);
    check("a_first_cpl", first_cpl, 21);
    check("a_done_cycle", done_k, 61);
    check("a_result", int'(bus.result), 7);
    check("a_alarm", int'(bus.alarm), 1);
    check("a_err", int'(bus.err), 0);

    // same word: no reload; a START while busy must be dropped
    do_start(4'b1010, 5'd8, 16'hF400, 16'hFFFF, 16'h0000, 16'hFFFF);
    repeat (10) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("run_b");
    check("b_sc_rises", rises, 0);
    check("b_first_cpl", first_cpl, 1);
    check("b_done_cycle", done_k, 41);
    check("b_result", int'(bus.result), 0);
    check("b_alarm", int'(bus.alarm), 1);
    check("b_err", int'(bus.err), 1);

    // all-ones at threshold 16; START coinciding with DONE is ignored
    do_start(4'b1010, 5'd16, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    begin
      int n = 0;
      while (!(m_active && (cyc - m_t0) == m_total) && n < 300) begin
        @(negedge clk);
        n++;
      end
      check("c_reached_done", int'(n < 300), 1);
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("run_c");
    repeat (3) @(negedge clk);
    check("c_busy_after_done_start", int'(bus.busy), 0);
    check("c_done_cycle", done_k, 41);
    check("c_result", int'(bus.result), 16);
    check("c_alarm", int'(bus.alarm), 0);
    check("c_err", int'(bus.err), 0);

    // abort during SHIFT bit 2, then during MEAS sample 2
    do_start(4'b0110, 5'd4, 16'hFFFF, 16'hFF00, 16'hF000, 16'h8000);
    abort_after(4);
    do_start(4'b0110, 5'd4, 16'hFFFF, 16'hFF00, 16'hF000, 16'h8000);
    abort_after(33);

    // previous word after abort must reload in full
    do_start(4'b0110, 5'd5, 16'hFFF0, 16'hFFFF, 16'hFFF8, 16'hFFFC);
    wait_done("run_d");
    check("d_sc_rises", rises, 4);
    check("d_din_at_rises", int'(rise_bits), 4'b0110);
    check("d_chain_latched", int'(latched), 4'b0110);
    check("d_first_cpl", first_cpl, 21);
    check("d_done_cycle", done_k, 61);
    check("d_result", int'(bus.result), 12);
    check("d_alarm", int'(bus.alarm), 0);
    check("d_err", int'(bus.err), 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/cpm_seq_ctrl.md
# cpm_seq_ctrl

Sequencer for one Critical Path Monitor macro. On each START it does three things:
- Loads the requested 4-bit path-select word through the serial scan-chain, skipping the load if that word is already loaded.
- Issues SAMPLES launch/capture pairs on CPL_CLK/TDC_CLK.
- Decodes each 16-bit thermometer word from the edge detector and reports the minimum edge position as worst-case slack, plus alarm and bubble-error flags.

It sits between the on-chip monitor bus and the CPM top-level pins, and replaces bench-driven pin wiggling.

## Interface
Parameters:
- SC_HALF, 2: CLK cycles per SC_CLK half-period and per SC_LEN pulse phase (≥1).
- CAP_DLY, 3: CLK cycles from CPL_CLK rise to TDC_CLK rise (≥1).
- RELAX, 4: idle CLK cycles after each sample decode (≥0).
- SAMPLES, 4: measurements per START (1..15).

Ports:
- CLK  in  1  single system clock; all outputs registered on posedge.
- RST  in  1  reset, asynchronous, active-low.
- START  in  1  request a run; sampled only in IDLE.
- CFG_SEL  in  4  path-select word; CFG_SEL[1..4] maps to S[1..4].
- THRESH  in  5  alarm threshold, edge-position units.
- CPM_OUT  in  16  thermometer word; bit 1 = first delay cell (MSB of [1:16]).
- SC_DIN, SC_CLK, SC_LEN  out  1 each  scan-chain serial data, clock and latch.
- CPL_CLK, TDC_CLK  out  1 each  launch and capture edges.
- BUSY  out  1  high from the cycle after START is accepted until DONE.
- DONE  out  1  one-cycle pulse when the result is valid.
- RESULT  out  5  minimum decoded edge position over the run (0..16).
- ALARM  out  1  RESULT < THRESH; THRESH sampled at START.
- ERR  out  1  at least one sample contained a bubble.

## Operation
- States: IDLE, SHIFT, LATCH, MEAS, EVAL.
- IDLE → SHIFT on START if cfg_valid=0 or CFG_SEL ≠ loaded word; otherwise IDLE → MEAS.
- CFG_SEL and THRESH are captured at START; later changes are ignored until the next run.
- START while BUSY is ignored; it is not queued.
- SHIFT:
  - Four bits, in order CFG_SEL[4], [3], [2], [1].
  - Per bit: SC_DIN is set and SC_CLK is held low for SC_HALF cycles, then SC_CLK is held high for SC_HALF cycles.
  - SC_DIN is stable across each SC_CLK rise.
  - SC_CLK is left low at the end.
- LATCH:
  - SC_LEN is high for SC_HALF cycles, then low for SC_HALF cycles.
  - SC_CLK stays low throughout.
  - cfg_valid is set to 1 and the loaded word becomes CFG_SEL.
- MEAS, per sample, with the window starting at cycle w=0:
  - w=0: CPL_CLK=1.
  - w=CAP_DLY: TDC_CLK=1.
  - w=CAP_DLY+1: CPL_CLK=0 and TDC_CLK=0.
  - w=CAP_DLY+2: CPM_OUT is registered and decoded.
  - Then RELAX idle cycles.
  - Window length P=CAP_DLY+3+RELAX.
- Decode:
  - count = number of consecutive 1s starting at bit 1. All-ones gives 16; bit 1 = 0 gives 0.
  - Bubble: any 1 at a bit position beyond the first 0. A bubble sets the run's err flag; count is still the leading-ones count.
  - Running minimum is initialised to 16 at START.
- EVAL (one cycle):
  - RESULT=min, ALARM=(min<THRESH), ERR=err, DONE=1.
  - Return to IDLE.
- Arithmetic: unsigned 5-bit values throughout; the comparison is strict.
- RESULT, ALARM and ERR hold their values until the next EVAL.

## Timing
- Reset values: every output 0 (SC_*, CPL_CLK, TDC_CLK, BUSY, DONE, RESULT, ALARM, ERR); cfg_valid=0; state IDLE.
- Reset asserted mid-run:
  - All outputs go to 0 immediately (asynchronous).
  - cfg_valid clears, so the next START always reloads the chain.
  - No DONE is issued for the aborted run.
- START accepted in cycle 0.
- First CPL_CLK rise:
  - Cycle 1 with no reload.
  - Cycle 1+10·SC_HALF with a reload.
- DONE occurs in cycle 1+L+SAMPLES·P, where L=10·SC_HALF with a reload and L=0 without.
- BUSY is high from cycle 1 through the DONE cycle inclusive.
- START in the same cycle as DONE is ignored.
- A new START is accepted from the cycle after DONE (IDLE).
- No output glitches: every output is a flop output.

## Test plan
- Reset: hold RST=0 with random START/CPM_OUT → all outputs 0. Release RST, then START with CFG_SEL=4'b1010 → SHIFT is entered.
- Reload, with SC_HALF=2:
  - START with CFG_SEL=4'b1010 → SC_DIN at the four SC_CLK rises is 0,1,0,1.
  - One SC_LEN pulse of 2 cycles with SC_CLK low.
  - A behavioural scan-chain model then shows S=1010.
  - First CPL_CLK rise at cycle 21.
- Skip reload:
  - Repeat START with the same CFG_SEL → no SC_CLK toggles, CPL_CLK rises at cycle 1.
  - With SAMPLES=4, CAP_DLY=3, RELAX=4, DONE is at cycle 41.
- Minimum and alarm:
  - SAMPLES=4, THRESH=8, CPM_OUT per sample = 16'hFF80, 16'hFE00, 16'hFF00, 16'hFFC0 (counts 9, 7, 8, 10).
  - Expected: RESULT=7, ALARM=1, ERR=0.
- Bubble and extremes:
  - CPM_OUT per sample = 16'hF400, then 16'hFFFF, 16'h0000, 16'hFFFF.
  - Expected: RESULT=0, ERR=1.
  - A further single run of 16'hFFFF with THRESH=16 → RESULT=16, ALARM=0.
- Abort:
  - Assert RST during SHIFT bit 2, then during MEAS sample 2 → outputs 0 at once, no DONE.
  - After release, START with the previous CFG_SEL performs a full reload.
